// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite renderer and the position/animation updater.
// No logic here: state encoding, screen/sprite geometry, colours and ROM address packing.
// Any change here affects both the renderer and the updater.
package sprite_pkg;

    localparam int SCREEN_W = 240;
    localparam int SCREEN_H = 320;
    localparam int SPRITE_W = 32;
    localparam int SPRITE_H = 32;
    localparam int SPR_XB   = $clog2(SPRITE_W);
    localparam int SPR_YB   = $clog2(SPRITE_H);
    localparam int ROM_AW   = 14;

    localparam logic [15:0] BG_COLOUR  = 16'h0000;
    localparam logic [15:0] KEY_COLOUR = 16'hF81F;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Sprite placement latched once per frame.
    typedef struct packed {
        logic [3:0] id;
        logic [8:0] y;
        logic [7:0] x;
    } sprite_pos_t;

    // ROM word address: frame index, then row, then column.
    function automatic logic [ROM_AW-1:0] rom_addr(input logic [3:0] id,
                                                   input logic [SPR_YB-1:0] row,
                                                   input logic [SPR_XB-1:0] col);
        return {id, row, col};
    endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// Bundle of the renderer's control, sprite-ROM and LCD-pixel signals.
// Pure wiring, no latency.
// pixelWrite/pixelReady is the only handshake; the ROM side has none.
interface sprite_renderer_if;
    import sprite_pkg::*;

    logic              start;
    logic [7:0]        xSprite;
    logic [8:0]        ySprite;
    logic [3:0]        ROMId;
    logic [ROM_AW-1:0] romAddr;
    logic [15:0]       romData;
    logic [7:0]        xAddr;
    logic [8:0]        yAddr;
    logic [15:0]       pixelData;
    logic              pixelWrite;
    logic              pixelReady;
    logic              busy;
    logic              frameDone;

    modport master (
        input  start, xSprite, ySprite, ROMId, romData, pixelReady,
        output romAddr, xAddr, yAddr, pixelData, pixelWrite, busy, frameDone
    );

    modport slave (
        output start, xSprite, ySprite, ROMId, romData, pixelReady,
        input  romAddr, xAddr, yAddr, pixelData, pixelWrite, busy, frameDone
    );

endinterface

// File: rtl/sprite_renderer_raster_counter.sv
// Raster-order x/y scan position over the screen, wrapping to (0,0) after the last pixel.
// Position updates on the clock edge where advance is high.
// Holds while advance is low; clear has priority over advance.
module raster_counter
    import sprite_pkg::*;
#(
    parameter int SCR_W = SCREEN_W,
    parameter int SCR_H = SCREEN_H
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_advance,
    output logic [7:0] o_x,
    output logic [8:0] o_y,
    output logic       o_last
);

    logic [7:0] r_x;
    logic [8:0] r_y;
    logic       w_x_end;
    logic       w_y_end;

    assign w_x_end = (r_x == 8'(SCR_W - 1));
    assign w_y_end = (r_y == 9'(SCR_H - 1));

    // Step along the line, moving to the next line when x wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : r_y + 9'd1;
            end else begin
                r_x <= r_x + 8'd1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_x_end && w_y_end;

endmodule

// File: rtl/sprite_renderer.sv
// Raster-scans the LCD, compositing one 32x32 sprite from a sync ROM over a flat background.
// Per pixel: 2 cycles background, 3 cycles sprite (extra cycle for ROM read), plus stall.
// pixelReady low freezes the WRITE state and all pixel outputs until the transfer.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SCR_W = SCREEN_W,
    parameter int SCR_H = SCREEN_H
) (
    input  logic              clock,
    input  logic              reset,
    sprite_renderer_if.master bus
);

    logic [2:0]        r_state;
    sprite_pos_t       r_sprite;
    logic [15:0]       r_pixel_data;

    logic [7:0]        w_x;
    logic [8:0]        w_y;
    logic              w_last;
    logic              w_clear;
    logic              w_advance;
    logic              w_inside;
    logic [9:0]        w_x_end;
    logic [9:0]        w_y_end;
    logic [SPR_XB-1:0] w_col;
    logic [SPR_YB-1:0] w_row;

    assign w_clear   = (r_state == ST_IDLE) && bus.start;
    assign w_advance = (r_state == ST_WRITE) && bus.pixelReady;

    raster_counter #(
        .SCR_W (SCR_W),
        .SCR_H (SCR_H)
    ) u_raster (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_last    (w_last)
    );

    // Upper bounds one bit wider than the coordinate so a sprite near 255/511 cannot wrap.
    assign w_x_end  = {2'b00, r_sprite.x} + 10'(SPRITE_W);
    assign w_y_end  = {1'b0,  r_sprite.y} + 10'(SPRITE_H);
    assign w_inside = (w_x >= r_sprite.x) && ({2'b00, w_x} < w_x_end) &&
                      (w_y >= r_sprite.y) && ({1'b0,  w_y} < w_y_end);

    // Only the low bits of the offset reach the ROM, and those depend only on the low bits.
    assign w_col = w_x[SPR_XB-1:0] - r_sprite.x[SPR_XB-1:0];
    assign w_row = w_y[SPR_YB-1:0] - r_sprite.y[SPR_YB-1:0];

    // Sequence each pixel: fetch/decide, optional ROM wait, then hold until the LCD accepts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_sprite     <= '0;
            r_pixel_data <= BG_COLOUR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_sprite <= '{id: bus.ROMId, y: bus.ySprite, x: bus.xSprite};
                        r_state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_inside) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_pixel_data <= BG_COLOUR;
                        r_state      <= ST_WRITE;
                    end
                end
                ST_WAIT: begin
                    r_pixel_data <= (bus.romData == KEY_COLOUR) ? BG_COLOUR : bus.romData;
                    r_state      <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (bus.pixelReady) begin
                        r_state <= w_last ? ST_DONE : ST_FETCH;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address is presented during FETCH so the synchronous ROM answers in WAIT.
    assign bus.romAddr    = (r_state == ST_FETCH && w_inside) ?
                            rom_addr(r_sprite.id, w_row, w_col) : '0;
    assign bus.xAddr      = w_x;
    assign bus.yAddr      = w_y;
    assign bus.pixelData  = r_pixel_data;
    assign bus.pixelWrite = (r_state == ST_WRITE);
    assign bus.busy       = (r_state == ST_FETCH) || (r_state == ST_WAIT) || (r_state == ST_WRITE);
    assign bus.frameDone  = (r_state == ST_DONE);

endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer on a reduced 48x40 screen.
// Every transferred pixel is compared against a behavioural compositing model.
// Probe vectors check single pixels and ROM addresses against hand-computed values.
module tb_sprite_renderer;
    import sprite_pkg::*;

    localparam int TW = 48;
    localparam int TH = 40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    sprite_renderer_if bus ();

    sprite_renderer #(
        .SCR_W (TW),
        .SCR_H (TH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Test ROM: each word is its own address, except one transparent-key entry.
    function automatic logic [15:0] rom_word(input logic [13:0] a);
        return (a == 14'h0800) ? 16'hF81F : {2'b00, a};
    endfunction

    always @(posedge clock) bus.romData <= rom_word(bus.romAddr);

    function automatic logic [15:0] exp_pix(input int x, input int y, input int xs,
                                            input int ys, input int id);
        logic [15:0] w;
        if (x >= xs && x < xs + 32 && y >= ys && y < ys + 32) begin
            w = rom_word(14'(id * 1024 + (y - ys) * 32 + (x - xs)));
            return (w == 16'hF81F) ? 16'h0000 : w;
        end
        return 16'h0000;
    endfunction

    function automatic int ovl(input int s, input int n);
        if (s >= n) return 0;
        return (s + 32 > n) ? n - s : 32;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_pixelWrite"}, 32'(bus.pixelWrite), 0);
        check({tag, "_busy"},       32'(bus.busy), 0);
        check({tag, "_frameDone"},  32'(bus.frameDone), 0);
        check({tag, "_xAddr"},      32'(bus.xAddr), 0);
        check({tag, "_yAddr"},      32'(bus.yAddr), 0);
        check({tag, "_romAddr"},    32'(bus.romAddr), 0);
        check({tag, "_pixelData"},  32'(bus.pixelData), 32'(BG_COLOUR));
    endtask

    // Render one frame, checking every pixel; optionally stall, disturb inputs,
    // abort with reset at the probe pixel, or raise start during DONE.
    task automatic run_frame(input int xs, input int ys, input int id, input int px,
                             input int py, input int stall, input bit disturb,
                             input bit abort, input bit done_start,
                             output logic [15:0] dcap, output logic [13:0] acap);
        int ex, ey, xfers, errs, held, done_c, exp_c;
        bit prev_xfer, xfer, seen_probe;
        logic [15:0] hd;
        logic [7:0]  hx;
        logic [8:0]  hy;
        ex = 0; ey = 0; xfers = 0; errs = 0; held = 0; done_c = -1;
        prev_xfer = 0; seen_probe = 0; dcap = 16'hDEAD; acap = 14'h3FFF;
        hd = '0; hx = '0; hy = '0;
        @(negedge clock);
        bus.pixelReady = 1'b1;
        bus.xSprite = 8'(xs); bus.ySprite = 9'(ys); bus.ROMId = 4'(id); bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 1);
        for (int c = 1; c < 20000; c++) begin
            if (disturb && c == 50) begin
                bus.xSprite = 8'd0; bus.ySprite = 9'd0; bus.ROMId = 4'hF; bus.start = 1'b1;
            end
            if (disturb && c == 51) bus.start = 1'b0;
            if (!seen_probe && bus.xAddr == 8'(px) && bus.yAddr == 9'(py)) begin
                seen_probe = 1; acap = bus.romAddr;
            end
            if (bus.frameDone) begin
                done_c = c;
                if (bus.busy) errs++;
                if (done_start) bus.start = 1'b1;
                break;
            end
            xfer = 0;
            if (bus.pixelWrite) begin
                if (bus.xAddr !== 8'(ex) || bus.yAddr !== 9'(ey)) errs++;
                if (bus.pixelData !== exp_pix(ex, ey, xs, ys, id)) errs++;
                if (prev_xfer) errs++;
                if (ex == px && ey == py) begin
                    if (abort) begin
                        reset = 1'b0;
                        break;
                    end
                    if (stall > 0) begin
                        if (held == 0) begin
                            hd = bus.pixelData; hx = bus.xAddr; hy = bus.yAddr;
                        end else if (bus.pixelData !== hd || bus.xAddr !== hx || bus.yAddr !== hy) begin
                            errs++;
                        end
                    end
                    if (held < stall) begin
                        bus.pixelReady = 1'b0; held++;
                    end else begin
                        bus.pixelReady = 1'b1;
                    end
                end
                xfer = bus.pixelReady;
                if (xfer) begin
                    if (ex == px && ey == py) dcap = bus.pixelData;
                    xfers++; ex++;
                    if (ex == TW) begin ex = 0; ey++; end
                end
            end
            if (!bus.busy) errs++;
            prev_xfer = xfer;
            @(negedge clock);
        end
        if (abort) begin
            #1;
            check_rst("abort");
            errs = 0;
            repeat (3) begin
                @(negedge clock);
                if (bus.frameDone || bus.busy) errs++;
            end
            check("abort_no_done", 32'(errs), 0);
            reset = 1'b1;
        end else begin
            exp_c = 1 + 2 * TW * TH + ovl(xs, TW) * ovl(ys, TH) + stall;
            check("frame_pixel_errs", 32'(errs), 0);
            check("frame_transfers", 32'(xfers), 32'(TW * TH));
            check("frame_done_cycle", 32'(done_c), 32'(exp_c));
            if (stall > 0) check("stall_cycles", 32'(held), 32'(stall));
            @(negedge clock);
            check("done_one_cycle", {30'd0, bus.frameDone, bus.busy}, 0);
        end
    endtask

    typedef struct packed {
        int          xs;
        int          ys;
        int          id;
        int          px;
        int          py;
        int          stall;
        bit          disturb;
        logic [15:0] exp_data;
        logic [13:0] exp_addr;
    } vec_t;

    vec_t        vecs [10];
    logic [15:0] dcap;
    logic [13:0] acap;

    initial begin
        vecs[0] = '{0,   0,  0,  5,  3, 0, 1'b0, 16'h0065, 14'h0065};
        vecs[1] = '{0,   0,  0, 32,  0, 0, 1'b0, 16'h0000, 14'h0000};
        vecs[2] = '{0,   0,  0, 31, 31, 0, 1'b0, 16'h03FF, 14'h03FF};
        vecs[3] = '{10,  5,  2, 10,  5, 0, 1'b0, 16'h0000, 14'h0800};
        vecs[4] = '{10,  5,  2, 11,  5, 0, 1'b0, 16'h0801, 14'h0801};
        vecs[5] = '{38, 30,  1, 47, 39, 0, 1'b0, 16'h0529, 14'h0529};
        vecs[6] = '{38, 30,  1, 37, 39, 0, 1'b0, 16'h0000, 14'h0000};
        vecs[7] = '{250, 5,  3,  5,  5, 0, 1'b0, 16'h0000, 14'h0000};
        vecs[8] = '{8,   8,  1, 10, 10, 7, 1'b0, 16'h0442, 14'h0442};
        vecs[9] = '{20, 12,  4, 21, 13, 0, 1'b1, 16'h1021, 14'h1021};

        bus.start = 1'b0; bus.xSprite = '0; bus.ySprite = '0; bus.ROMId = '0;
        bus.pixelReady = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check_rst("reset");
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("idle_pixelWrite", 32'(bus.pixelWrite), 0);
        check("idle_busy", 32'(bus.busy), 0);

        // Abort mid-frame; the following vectors then confirm a fresh scan from (0,0).
        run_frame(0, 0, 0, 24, 20, 0, 1'b0, 1'b1, 1'b0, dcap, acap);

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i].xs, vecs[i].ys, vecs[i].id, vecs[i].px, vecs[i].py,
                      vecs[i].stall, vecs[i].disturb, 1'b0, 1'b0, dcap, acap);
            check($sformatf("vec%0d_data", i), 32'(dcap), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_romAddr", i), 32'(acap), 32'(vecs[i].exp_addr));
        end

        // start raised during DONE is ignored, then accepted in the following IDLE cycle.
        run_frame(0, 0, 0, 5, 3, 0, 1'b0, 1'b0, 1'b1, dcap, acap);
        @(negedge clock);
        bus.start = 1'b0;
        check("start_after_done_busy", 32'(bus.busy), 1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
